miq_issue_arbiter: RTL

//  Consumer end of the two miq_ifc outputs of the banked in-order IQ. Each cycle selects the

---
 rtl/miq_issue_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/miq_issue_arbiter.sv
// ---------------------------------------------------------------------------
// miq_issue_arbiter
//   Consumer end of the two bank outputs of the banked in-order issue queue.
//   Each cycle picks the older of the two bank heads (by active-list age
//   relative to old_front) and loads it into a single registered issue slot
//   that drives the memory pipe. A held op younger than or equal to the
//   recall boundary is squashed on if_recall, and bank handshakes are
//   suppressed while stalled, during a recall and for one cycle after it.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   ext_stall             global stall, blocks bank handshakes
//   if_recall             branch recall pulse
//   old_front             oldest live active-list entry (age origin)
//   new_front             recall boundary
//   i_valid[1:0]          bank head valid
//   i_al_addr/op/base/src/imm [2]  bank head fields
//   o_ready[1:0]          bank head consumed this cycle (combinational)
//   m_valid, m_al_addr, m_op, m_base, m_src, m_imm  issue slot
//   m_ready               memory pipe accepts the slot this cycle
// ---------------------------------------------------------------------------
module miq_issue_arbiter #(
    parameter int unsigned AL_ADDR_W = 6,
    parameter int unsigned PREG_W    = 7,
    parameter int unsigned IMM_W     = 32,
    parameter int unsigned OP_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ext_stall,
    input  logic                 if_recall,
    input  logic [AL_ADDR_W-1:0] old_front,
    input  logic [AL_ADDR_W-1:0] new_front,
    input  logic [1:0]           i_valid,
    input  logic [AL_ADDR_W-1:0] i_al_addr [2],
    input  logic [OP_W-1:0]      i_op      [2],
    input  logic [PREG_W-1:0]    i_base    [2],
    input  logic [PREG_W-1:0]    i_src     [2],
    input  logic [IMM_W-1:0]     i_imm     [2],
    output logic [1:0]           o_ready,
    output logic                 m_valid,
    output logic [AL_ADDR_W-1:0] m_al_addr,
    output logic [OP_W-1:0]      m_op,
    output logic [PREG_W-1:0]    m_base,
    output logic [PREG_W-1:0]    m_src,
    output logic [IMM_W-1:0]     m_imm,
    input  logic                 m_ready
);

    logic                 valid_q,  valid_d;
    logic [AL_ADDR_W-1:0] al_q,     al_d;
    logic [OP_W-1:0]      op_q,     op_d;
    logic [PREG_W-1:0]    base_q,   base_d;
    logic [PREG_W-1:0]    src_q,    src_d;
    logic [IMM_W-1:0]     imm_q,    imm_d;
    logic                 recall_q;

    logic [AL_ADDR_W-1:0] age0, age1, age_m, age_nf;
    logic [1:0]           grant;
    logic                 slot_free;
    logic                 squash;
    logic                 sel;

    // Modular distance from old_front; wraps naturally at 2^AL_ADDR_W.
    always_comb begin
        age0   = i_al_addr[0] - old_front;
        age1   = i_al_addr[1] - old_front;
        age_m  = al_q - old_front;
        age_nf = new_front - old_front;
    end

    // Single arbitration point; equal ages fall to bank 0.
    always_comb begin
        grant = '0;
        if (i_valid[0] && i_valid[1]) begin
            if (age1 < age0) grant = 2'b10;
            else             grant = 2'b01;
        end else if (i_valid[0]) begin
            grant = 2'b01;
        end else if (i_valid[1]) begin
            grant = 2'b10;
        end
    end

    always_comb begin
        slot_free = !valid_q || m_ready;
        o_ready   = '0;
        if (slot_free && !ext_stall && !if_recall && !recall_q && !reset)
            o_ready = grant;
        squash = if_recall && valid_q && (age_m >= age_nf);
        sel    = o_ready[1];
    end

    always_comb begin
        valid_d = valid_q;
        al_d    = al_q;
        op_d    = op_q;
        base_d  = base_q;
        src_d   = src_q;
        imm_d   = imm_q;
        if (|o_ready) begin
            // Drain and refill share this branch, so m_ready needs no special case here.
            valid_d = 1'b1;
            al_d    = i_al_addr[sel];
            op_d    = i_op[sel];
            base_d  = i_base[sel];
            src_d   = i_src[sel];
            imm_d   = i_imm[sel];
        end else if (squash) begin
            valid_d = 1'b0;
        end else if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            al_q     <= '0;
            op_q     <= '0;
            base_q   <= '0;
            src_q    <= '0;
            imm_q    <= '0;
            recall_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            al_q     <= al_d;
            op_q     <= op_d;
            base_q   <= base_d;
            src_q    <= src_d;
            imm_q    <= imm_d;
            recall_q <= if_recall;
        end
    end

    assign m_valid   = valid_q;
    assign m_al_addr = al_q;
    assign m_op      = op_q;
    assign m_base    = base_q;
    assign m_src     = src_q;
    assign m_imm     = imm_q;

endmodule
